// File: rtl/life_pkg.sv
// Shared FSM state type, Life rule constants and the neighbour popcount
// used by the row engine and its per-column cells.
package life_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [3:0] LIFE_BIRTH_COUNT   = 4'd3;
    localparam logic [3:0] LIFE_SURVIVE_COUNT = 4'd2;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

endpackage

// File: rtl/life_row_engine_if.sv
// Row stream interface between producer, Life row engine and consumer.
// A beat moves on a rising edge when valid & ready are both 1; the sender
// holds data/valid stable until that edge, and ready may depend on valid.
interface life_row_engine_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_row;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_row;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport engine (
        input  in_row, in_valid, out_ready,
        output in_ready, out_row, out_valid, out_last
    );

    modport env (
        output in_row, in_valid, out_ready,
        input  in_ready, out_row, out_valid, out_last
    );
endinterface

// File: rtl/life_cell.sv
// One column of the Life rule: popcount of the 8 neighbours, then
// birth on exactly 3, survival on exactly 2 for a live cell.
module life_cell
    import life_pkg::*;
(
    input  logic [7:0] nbr,
    input  logic       alive,
    output logic       alive_next
);
    logic [3:0] count;

    assign count      = popcount8(nbr);
    assign alive_next = (count == LIFE_BIRTH_COUNT) |
                        (alive & (count == LIFE_SURVIVE_COUNT));
endmodule

// File: rtl/life_row_engine.sv
// Streaming Conway next-generation engine: two-row line buffer, one life_cell
// per column, registered output slot. Define LIFE_ROW_WRAP_EN for toroidal columns.
module life_row_engine
    import life_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    life_row_engine_if.engine    bus,
    output state_t               fsm_state
);
    localparam int CW = $clog2(HEIGHT);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] above;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] below;
    logic [WIDTH-1:0] next_row;
    logic [WIDTH-1:0] out_row_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             slot_free;
    logic             in_ready;
    logic             in_xfer;
    logic             last_in;
    logic             load_out;
    logic [WIDTH+1:0] above_x;
    logic [WIDTH+1:0] cur_x;
    logic [WIDTH+1:0] below_x;

    assign slot_free = !out_valid_q | bus.out_ready;
    assign in_xfer   = bus.in_valid & in_ready;
    assign last_in   = (count == CW'(HEIGHT - 1));
    // The row below the last row of the frame is dead.
    assign below     = (state == FLUSH) ? '0 : bus.in_row;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load_out  = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = STREAM;
            end
            STREAM: begin
                in_ready = slot_free;
                if (bus.in_valid && slot_free) begin
                    load_out = 1'b1;
                    if (last_in) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load_out  = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            count       <= '0;
            above       <= '0;
            cur         <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_xfer) begin
                cur <= bus.in_row;
                if (state == FILL) begin
                    above <= '0;
                    count <= CW'(1);
                end else begin
                    above <= cur;
                    if (!last_in) count <= count + CW'(1);
                end
            end else if (state == FLUSH && slot_free) begin
                count <= '0;
            end

            // A load and a drain in the same cycle simply replace the slot.
            if (load_out) begin
                out_row_q   <= next_row;
                out_valid_q <= 1'b1;
                out_last_q  <= (state == FLUSH);
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Padded rows: index j holds column j-1, so 0 and WIDTH+1 are the edges.
`ifdef LIFE_ROW_WRAP_EN
    assign above_x = {above[0], above, above[WIDTH-1]};
    assign cur_x   = {cur[0],   cur,   cur[WIDTH-1]};
    assign below_x = {below[0], below, below[WIDTH-1]};
`else
    assign above_x = {1'b0, above, 1'b0};
    assign cur_x   = {1'b0, cur,   1'b0};
    assign below_x = {1'b0, below, 1'b0};
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        logic [7:0] nbr;
        assign nbr = {above_x[i+2], above_x[i+1], above_x[i],
                      cur_x[i+2],                 cur_x[i],
                      below_x[i+2], below_x[i+1], below_x[i]};
        life_cell u_cell (
            .nbr        (nbr),
            .alive      (cur[i]),
            .alive_next (next_row[i])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_row   = out_row_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign fsm_state     = state;
endmodule

// File: tb/tb_life_row_engine.sv
// Bench for life_row_engine: three instances (HEIGHT 5/4/3, WIDTH 8) behind a
// select mux, scoreboard queue of {last,row}, scenario tasks, one summary line.
`timescale 1ns/1ps
module tb_life_row_engine;
  import life_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  life_row_engine_if #(.WIDTH(W)) bus5 ();
  life_row_engine_if #(.WIDTH(W)) bus4 ();
  life_row_engine_if #(.WIDTH(W)) bus3 ();
  state_t st5, st4, st3;

  life_row_engine #(.WIDTH(W), .HEIGHT(5)) u_h5 (.clk(clk), .rst_n(rst_n), .bus(bus5), .fsm_state(st5));
  life_row_engine #(.WIDTH(W), .HEIGHT(4)) u_h4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .fsm_state(st4));
  life_row_engine #(.WIDTH(W), .HEIGHT(3)) u_h3 (.clk(clk), .rst_n(rst_n), .bus(bus3), .fsm_state(st3));

  // ---------------- driver-side mux ----------------
  int sel = 0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] in_row = '0;
  logic in_ready, o_valid, o_last;
  logic [W-1:0] o_row;
  state_t o_state;

  always_comb begin
    bus5.in_row = in_row;
    bus4.in_row = in_row;
    bus3.in_row = in_row;
    bus5.in_valid = in_valid && (sel == 0);
    bus4.in_valid = in_valid && (sel == 1);
    bus3.in_valid = in_valid && (sel == 2);
    bus5.out_ready = (sel == 0) ? out_ready : 1'b1;
    bus4.out_ready = (sel == 1) ? out_ready : 1'b1;
    bus3.out_ready = (sel == 2) ? out_ready : 1'b1;
  end

  always_comb begin
    in_ready = bus5.in_ready;
    o_valid  = bus5.out_valid;
    o_last   = bus5.out_last;
    o_row    = bus5.out_row;
    o_state  = st5;
    if (sel == 1) begin
      in_ready = bus4.in_ready;
      o_valid  = bus4.out_valid;
      o_last   = bus4.out_last;
      o_row    = bus4.out_row;
      o_state  = st4;
    end else if (sel == 2) begin
      in_ready = bus3.in_ready;
      o_valid  = bus3.out_valid;
      o_last   = bus3.out_last;
      o_row    = bus3.out_row;
      o_state  = st3;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [W:0] exp_q[$];

  function automatic logic [W-1:0] model_next(input logic [W-1:0] a, input logic [W-1:0] c,
                                              input logic [W-1:0] b);
    logic [W-1:0] r;
    int cnt, col;
    r = '0;
    for (int i = 0; i < W; i++) begin
      cnt = 0;
      for (int d = -1; d <= 1; d++) begin
        col = i + d;
`ifdef LIFE_ROW_WRAP_EN
        col = (col + W) % W;
`endif
        if (col >= 0 && col < W) begin
          cnt = cnt + int'(a[col]) + int'(b[col]);
          if (d != 0) cnt = cnt + int'(c[col]);
        end
      end
      r[i] = (cnt == 3) || (c[i] && cnt == 2);
    end
    return r;
  endfunction

  function automatic void push_model_frame(input logic [W-1:0] rows[16], input int base, input int h);
    logic [W-1:0] a, b;
    for (int r = 0; r < h; r++) begin
      a = (r == 0) ? '0 : rows[base + r - 1];
      b = (r == h - 1) ? '0 : rows[base + r + 1];
      exp_q.push_back({(r == h - 1), model_next(a, rows[base + r], b)});
    end
  endfunction

  // Drives n rows into the selected engine and pops/compares every output beat.
  task automatic run_stream(input logic [W-1:0] rows[16], input int n, input int stall_len,
                            input bit rnd, output int cycles, output int gaps);
    int idx = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    bit seen = 1'b0;
    logic [W:0] e;
    cycles = 0;
    gaps = 0;
    while ((idx < n || exp_q.size() > 0) && cycles < 300) begin
      @(negedge clk);
      in_valid = (idx < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_row = (idx < n) ? rows[idx] : '0;
      if (!rnd && stall_len > 0 && !stalled && o_valid) begin
        stalled = 1'b1;
        stall_left = stall_len;
      end
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        n_checks++;
        if (exp_q.size() == 0 || o_valid !== 1'b1 || o_row !== exp_q[0][W-1:0]) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b row=%h, want held front of queue", o_valid, o_row);
        end
        stall_left--;
      end
      if (o_valid) seen = 1'b1;
      else if (seen && exp_q.size() > 0) gaps++;
      if (o_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got last=%b row=%h with empty queue", o_last, o_row);
        end else begin
          e = exp_q.pop_front();
          if ({o_last, o_row} !== e) begin
            n_fail++;
            $display("FAIL out_row: got last=%b row=%h want last=%b row=%h",
                     o_last, o_row, e[W], e[W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) idx++;
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (idx < n || exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL timeout: accepted %0d of %0d rows, %0d outputs outstanding", idx, n, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({bus5.out_valid, bus4.out_valid, bus3.out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 000", {bus5.out_valid, bus4.out_valid, bus3.out_valid});
    end
    n_checks++;
    if ({bus5.out_last, bus4.out_last, bus3.out_last} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_out_last: got %b want 000", {bus5.out_last, bus4.out_last, bus3.out_last});
    end
    n_checks++;
    if ((bus5.out_row | bus4.out_row | bus3.out_row) !== '0) begin
      n_fail++;
      $display("FAIL reset_out_row: got %h/%h/%h want 00", bus5.out_row, bus4.out_row, bus3.out_row);
    end
    n_checks++;
    if ({bus5.in_ready, bus4.in_ready, bus3.in_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 111", {bus5.in_ready, bus4.in_ready, bus3.in_ready});
    end
    n_checks++;
    if (st5 !== FILL || st4 !== FILL || st3 !== FILL) begin
      n_fail++;
      $display("FAIL reset_state: got %0d/%0d/%0d want FILL", st5, st4, st3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_blinker_out();
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h1C});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
  endtask

  task automatic load_blinker(inout logic [W-1:0] rows[16], input int base);
    rows[base + 0] = 8'h00;
    rows[base + 1] = 8'h08;
    rows[base + 2] = 8'h08;
    rows[base + 3] = 8'h08;
    rows[base + 4] = 8'h00;
  endtask

  task automatic test_blinker();
    logic [W-1:0] rows[16];
    int cycles, gaps;
    rows = '{default: '0};
    load_blinker(rows, 0);
    sel = 0;
    push_blinker_out();
    run_stream(rows, 5, 0, 1'b0, cycles, gaps);
    n_checks++;
    if (cycles !== 7) begin
      n_fail++;
      $display("FAIL blinker_cycles: got %0d want 7", cycles);
    end
    n_checks++;
    if (gaps !== 0) begin
      n_fail++;
      $display("FAIL blinker_gaps: got %0d want 0", gaps);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL blinker_idle: got out_valid=%b want 0", o_valid);
      end
    end
  endtask

  task automatic test_block();
    logic [W-1:0] rows[16];
    int cycles, gaps;
    rows = '{default: '0};
    rows[1] = 8'h18;
    rows[2] = 8'h18;
    sel = 1;
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h18});
    exp_q.push_back({1'b0, 8'h18});
    exp_q.push_back({1'b1, 8'h00});
    run_stream(rows, 4, 0, 1'b0, cycles, gaps);
    n_checks++;
    if (cycles !== 6) begin
      n_fail++;
      $display("FAIL block_cycles: got %0d want 6", cycles);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] rows[16];
    int cycles, gaps;
    rows = '{default: '0};
    load_blinker(rows, 0);
    sel = 0;
    push_blinker_out();
    run_stream(rows, 5, 3, 1'b0, cycles, gaps);
    n_checks++;
    if (cycles !== 10) begin
      n_fail++;
      $display("FAIL backpressure_cycles: got %0d want 10", cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rows[16];
    int cycles, gaps;
    rows = '{default: '0};
    load_blinker(rows, 0);
    load_blinker(rows, 5);
    sel = 0;
    push_blinker_out();
    push_blinker_out();
    run_stream(rows, 10, 0, 1'b0, cycles, gaps);
    n_checks++;
    if (cycles !== 13) begin
      n_fail++;
      $display("FAIL b2b_cycles: got %0d want 13", cycles);
    end
    n_checks++;
    if (gaps !== 1) begin
      n_fail++;
      $display("FAIL b2b_gaps: got %0d want 1", gaps);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] rows[16];
    logic [W-1:0] e;
    int cycles, gaps;
    rows = '{default: '0};
    rows[1] = 8'h83;
    sel = 2;
`ifdef LIFE_ROW_WRAP_EN
    e = 8'h01;
`else
    e = 8'h00;
`endif
    exp_q.push_back({1'b0, e});
    exp_q.push_back({1'b0, e});
    exp_q.push_back({1'b1, e});
    run_stream(rows, 3, 0, 1'b0, cycles, gaps);
    n_checks++;
    if (cycles !== 5) begin
      n_fail++;
      $display("FAIL wrap_cycles: got %0d want 5", cycles);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] rows[16];
    int cycles, gaps;
    int k = 0;
    int guard = 0;
    rows = '{default: '0};
    load_blinker(rows, 0);
    sel = 0;
    out_ready = 1'b1;
    while (k < 3 && guard < 20) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_row = rows[k];
      #1;
      if (in_ready) k++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || in_ready !== 1'b1 || o_state !== FILL) begin
      n_fail++;
      $display("FAIL midreset_state: got valid=%b in_ready=%b state=%0d want 0/1/FILL",
               o_valid, in_ready, o_state);
    end
    push_blinker_out();
    run_stream(rows, 5, 0, 1'b0, cycles, gaps);
    n_checks++;
    if (cycles !== 7) begin
      n_fail++;
      $display("FAIL midreset_cycles: got %0d want 7", cycles);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_idle: got out_valid=%b want 0", o_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] rows[16];
    int cycles, gaps;
    rows = '{default: '0};
    for (int i = 0; i < 15; i++) rows[i] = W'($urandom_range(0, 255));
    sel = 0;
    for (int f = 0; f < 3; f++) push_model_frame(rows, f * 5, 5);
    run_stream(rows, 15, 0, 1'b1, cycles, gaps);
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
